// File: rtl/execute_muldiv_if.sv
// ============================================================================
// Module   : execute_muldiv_if
// Brief    : ID/EX -> EX/MEM bundle for the execute stage with mul/div unit:
//            decoded operands, forwarding sources, pipeline outputs, stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_muldiv_if #(
   parameter int LEN         = 32,
   parameter int NB          = 5,
   parameter int LEN_MEM_BUS = 9,
   parameter int LEN_WB_BUS  = 2
);
   // From the ID/EX register
   logic [LEN-1:0]         in_pc_branch;
   logic [LEN-1:0]         in_reg1;
   logic [LEN-1:0]         in_reg2;
   logic [LEN-1:0]         in_sign_extend;
   logic [NB-1:0]          in_rs;
   logic [NB-1:0]          in_rt;
   logic [NB-1:0]          in_rd;
   logic [NB-1:0]          in_shamt;
   logic [10:0]            execute_bus;
   logic [LEN_MEM_BUS-1:0] memory_bus;
   logic [LEN_WB_BUS-1:0]  writeBack_bus;
   // Forwarding sources
   logic                   register_write_3_4;
   logic                   register_write_4_5;
   logic [NB-1:0]          rd_3_4;
   logic [NB-1:0]          rd_4_5;
   logic [LEN-1:0]         in_mem_forw;
   logic [LEN-1:0]         in_wb_forw;
   logic                   flush;
   // To the EX/MEM register and hazard unit
   logic [LEN-1:0]         out_pc_branch;
   logic [LEN-1:0]         out_alu;
   logic [LEN-1:0]         out_reg2;
   logic                   zero_flag;
   logic [NB-1:0]          out_write_reg;
   logic [LEN_MEM_BUS-1:0] memory_bus_out;
   logic [LEN_WB_BUS-1:0]  writeBack_bus_out;
   logic                   stall_out;
   logic                   md_busy;

   modport master (
      output in_pc_branch, in_reg1, in_reg2, in_sign_extend,
      output in_rs, in_rt, in_rd, in_shamt, execute_bus, memory_bus, writeBack_bus,
      output register_write_3_4, register_write_4_5, rd_3_4, rd_4_5,
      output in_mem_forw, in_wb_forw, flush,
      input  out_pc_branch, out_alu, out_reg2, zero_flag, out_write_reg,
      input  memory_bus_out, writeBack_bus_out, stall_out, md_busy
   );

   modport slave (
      input  in_pc_branch, in_reg1, in_reg2, in_sign_extend,
      input  in_rs, in_rt, in_rd, in_shamt, execute_bus, memory_bus, writeBack_bus,
      input  register_write_3_4, register_write_4_5, rd_3_4, rd_4_5,
      input  in_mem_forw, in_wb_forw, flush,
      output out_pc_branch, out_alu, out_reg2, zero_flag, out_write_reg,
      output memory_bus_out, writeBack_bus_out, stall_out, md_busy
   );
endinterface

`default_nettype wire

// File: rtl/execute_muldiv.sv
// ============================================================================
// Module   : execute_muldiv
// Brief    : MIPS execute stage with operand forwarding, ALU and an iterative
//            shift-add multiplier / restoring divider holding HI and LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_muldiv #(
   parameter int LEN         = 32,
   parameter int NB          = 5,
   parameter int LEN_MEM_BUS = 9,
   parameter int LEN_WB_BUS  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   execute_muldiv_if.slave ex
);

   localparam int SHW = $clog2(LEN);
   localparam int CW  = $clog2(LEN + 1);

   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MFHI  = 3'd5;
   localparam logic [2:0] MD_MFLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } md_state_t;

   // Decode / datapath wires
   logic [2:0]       md_op;
   logic             md_req, md_start, stall, is_signed, is_div;
   logic [LEN-1:0]   fwd_a, fwd_b, op1, op2, alu_res, result;
   logic [LEN-1:0]   abs_a, abs_b;
   logic             a_neg, b_neg;
   logic [NB-1:0]    write_reg;

   // Unit step wires
   logic [LEN:0]     mul_sum;
   logic [LEN:0]     div_shift;
   logic [LEN-1:0]   div_sub;
   logic             div_ge;
   logic [2*LEN-1:0] prod, prod_fix;

   // Unit state
   md_state_t        state_q;
   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [LEN-1:0]   hi_q, lo_q, acc_hi_q, acc_lo_q, opnd_q;
   logic             neg_res_q, neg_rem_q, is_div_q, b_zero_q;

   // EX/MEM pipeline register
   logic [LEN-1:0]         pcb_d, alu_d, reg2_d, pcb_q, alu_q, reg2_q;
   logic                   zero_d, zero_q;
   logic [NB-1:0]          wreg_d, wreg_q;
   logic [LEN_MEM_BUS-1:0] mem_d, mem_q;
   logic [LEN_WB_BUS-1:0]  wb_d, wb_q;

   assign md_op    = ex.execute_bus[10:8];
   assign md_req   = (md_op >= MD_MULT) && (md_op <= MD_MFLO);
   assign stall    = busy_q & md_req & ~ex.flush;
   assign md_start = (state_q == S_IDLE) && (md_op >= MD_MULT) && (md_op <= MD_DIVU)
                     && !ex.flush && !stall;
   assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign is_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);

   // Operand forwarding: EX/MEM has priority over MEM/WB, register 0 never forwards
   always_comb begin
      fwd_a = ex.in_reg1;
      if (ex.register_write_4_5 && (ex.rd_4_5 != '0) && (ex.rd_4_5 == ex.in_rs))
         fwd_a = ex.in_wb_forw;
      if (ex.register_write_3_4 && (ex.rd_3_4 != '0) && (ex.rd_3_4 == ex.in_rs))
         fwd_a = ex.in_mem_forw;
      fwd_b = ex.in_reg2;
      if (ex.register_write_4_5 && (ex.rd_4_5 != '0) && (ex.rd_4_5 == ex.in_rt))
         fwd_b = ex.in_wb_forw;
      if (ex.register_write_3_4 && (ex.rd_3_4 != '0) && (ex.rd_3_4 == ex.in_rt))
         fwd_b = ex.in_mem_forw;
   end

   // ALU operand selection, ALU and destination register
   always_comb begin
      if (ex.execute_bus[7])      op1 = ex.in_pc_branch;
      else if (ex.execute_bus[5]) op1 = {{(LEN-NB){1'b0}}, ex.in_shamt};
      else                        op1 = fwd_a;
      if (ex.execute_bus[7])      op2 = {{(LEN-1){1'b0}}, 1'b1};
      else if (ex.execute_bus[4]) op2 = ex.in_sign_extend;
      else                        op2 = fwd_b;

      case (ex.execute_bus[3:0])
         4'd0:    alu_res = op1 + op2;
         4'd1:    alu_res = op1 - op2;
         4'd2:    alu_res = op1 & op2;
         4'd3:    alu_res = op1 | op2;
         4'd4:    alu_res = op1 ^ op2;
         4'd5:    alu_res = ~(op1 | op2);
         4'd6:    alu_res = {{(LEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         4'd7:    alu_res = {{(LEN-1){1'b0}}, (op1 < op2)};
         4'd8:    alu_res = op2 << op1[SHW-1:0];
         4'd9:    alu_res = op2 >> op1[SHW-1:0];
         4'd10:   alu_res = $signed(op2) >>> op1[SHW-1:0];
         4'd11:   alu_res = op2 << (LEN / 2);
         default: alu_res = '0;
      endcase

      if (md_op == MD_MFHI)      result = hi_q;
      else if (md_op == MD_MFLO) result = lo_q;
      else                       result = alu_res;

      if (ex.execute_bus[7])      write_reg = '1;
      else if (ex.execute_bus[6]) write_reg = ex.in_rd;
      else                        write_reg = ex.in_rt;
   end

   // Magnitudes for signed ops and one iteration step of each algorithm
   always_comb begin
      a_neg     = is_signed & fwd_a[LEN-1];
      b_neg     = is_signed & fwd_b[LEN-1];
      abs_a     = a_neg ? -fwd_a : fwd_a;
      abs_b     = b_neg ? -fwd_b : fwd_b;
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(LEN+1){1'b0}});
      div_shift = {acc_hi_q, acc_lo_q[LEN-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_sub   = div_shift[LEN-1:0] - opnd_q;
      prod      = {acc_hi_q, acc_lo_q};
      prod_fix  = neg_res_q ? -prod : prod;
   end

   // Multiply/divide sequencer: latch operands, iterate LEN times, sign-fix and commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         b_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (md_start) begin
                  state_q   <= S_RUN;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  acc_hi_q  <= '0;
                  acc_lo_q  <= is_div ? abs_a : abs_b;
                  opnd_q    <= is_div ? abs_b : abs_a;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  is_div_q  <= is_div;
                  b_zero_q  <= (fwd_b == '0);
               end
            end
            S_RUN: begin
               if (is_div_q) begin
                  acc_hi_q <= div_ge ? div_sub : div_shift[LEN-1:0];
                  acc_lo_q <= {acc_lo_q[LEN-2:0], div_ge};
               end else begin
                  acc_hi_q <= mul_sum[LEN:1];
                  acc_lo_q <= {mul_sum[0], acc_lo_q[LEN-1:1]};
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(LEN - 1))
                  state_q <= S_FIX;
            end
            S_FIX: begin
               if (is_div_q) begin
                  // Remainder follows the dividend sign; this also restores the
                  // original dividend into HI for a zero divisor.
                  hi_q <= neg_rem_q ? -acc_hi_q : acc_hi_q;
                  if (b_zero_q) lo_q <= '1;
                  else          lo_q <= neg_res_q ? -acc_lo_q : acc_lo_q;
               end else begin
                  hi_q <= prod_fix[2*LEN-1:LEN];
                  lo_q <= prod_fix[LEN-1:0];
               end
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Next EX/MEM contents: bubble on flush or stall, otherwise the executed instruction
   always_comb begin
      pcb_d  = '0;
      alu_d  = '0;
      reg2_d = '0;
      zero_d = 1'b0;
      wreg_d = '0;
      mem_d  = '0;
      wb_d   = '0;
      if (!ex.flush && !stall) begin
         pcb_d  = ex.in_pc_branch + ex.in_sign_extend;
         alu_d  = result;
         reg2_d = fwd_b;
         zero_d = (result == '0);
         wreg_d = write_reg;
         mem_d  = ex.memory_bus;
         wb_d   = ex.writeBack_bus;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcb_q  <= '0;
         alu_q  <= '0;
         reg2_q <= '0;
         zero_q <= 1'b0;
         wreg_q <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
      end else begin
         pcb_q  <= pcb_d;
         alu_q  <= alu_d;
         reg2_q <= reg2_d;
         zero_q <= zero_d;
         wreg_q <= wreg_d;
         mem_q  <= mem_d;
         wb_q   <= wb_d;
      end
   end

   assign ex.out_pc_branch     = pcb_q;
   assign ex.out_alu           = alu_q;
   assign ex.out_reg2          = reg2_q;
   assign ex.zero_flag         = zero_q;
   assign ex.out_write_reg     = wreg_q;
   assign ex.memory_bus_out    = mem_q;
   assign ex.writeBack_bus_out = wb_q;
   assign ex.stall_out         = stall;
   assign ex.md_busy           = busy_q;

endmodule

`default_nettype wire
